stall_scheduler: RTL and testbench
==================================

// Module: stall_scheduler
// PURPOSE
//  Arbitrates several pipeline-stall requesters (memory wait, multiply, branch flush) that share one
//  PC-enable delay resource. Each requester strobes a request with a cycle count. The block serves
//  requests one at a time in fixed priority and holds pcEn low for exactly that many cycles per grant.
//  Sits between the stall sources and the program counter; it replaces per-source delay counters.
// PARAMETERS
//  NUM_REQ     3   number of requesters; index 0 has the highest priority
//  DELAY_BITS  3   width of each delay field; max stall per grant = 2**DELAY_BITS-1 cycles
// PORTS
//  clk       in   1                   system clock, rising edge
//  reset     in   1                   asynchronous, active-high; clears all state
//  reqEn     in   NUM_REQ             1-cycle request strobe per requester, sampled at clk edge
//  reqDelay  in   NUM_REQ*DELAY_BITS  stall length for requester i in bits [i*DELAY_BITS +: DELAY_BITS]
//  pcEn      out  1                   1 = PC may advance; 0 = stalled
//  grant     out  NUM_REQ             one-hot, the requester currently being served; 0 when idle
//  done      out  NUM_REQ             1-cycle pulse when requester i's stall completes
// BEHAVIOUR
//  Reset: pcEn=1, grant=0, done=0, pending=0, count=0, state=IDLE. Reset is asynchronous and applies mid-stall.
//  All outputs are registered. reqDelay is sampled only with its reqEn strobe. A delay of 0 is treated as 1.
//  pending[i] is set by reqEn[i]; pendDelay[i] holds the sampled delay. A strobe while pending[i]=1 is ignored
//   and the first delay is kept. A strobe from the granted requester sets pending again and causes one rerun.
//  FSM states: IDLE, COUNT.
//  IDLE: cand = pending | reqEn. If cand != 0, at this edge:
//   - w = lowest set index of cand;
//   - grant<=onehot(w), count<=D(w), pcEn<=0, state<=COUNT;
//   - clear pending[w]; D(w) comes from reqDelay when strobed this cycle, otherwise from pendDelay.
//  COUNT, count>1: count<=count-1; pcEn stays 0.
//  COUNT, count==1 (completion edge):
//   - done[w]<=1 for one cycle;
//   - if (pending|reqEn) != 0, grant the next winner as in IDLE back-to-back, and pcEn stays 0;
//   - otherwise grant<=0, pcEn<=1, state<=IDLE.
//  Latency: strobe captured at edge k -> pcEn=0 from edge k; pcEn low for exactly D cycles; rises at edge k+D.
//  Back-to-back grants give a total stall equal to the sum of the delays, with no pcEn=1 gap.
//  Priority is fixed and non-preemptive. A higher-priority request arriving mid-COUNT waits for completion.
//  Simultaneous strobes from several requesters are all latched; they are served in index order.
//  Width rule: count is DELAY_BITS wide, with no wrap. Decrement happens only when count>1.
// STRUCTURE
//  Shared package pkg_stall: state typedef {IDLE, COUNT}, DELAY_BITS default, function for
//   lowest-index one-hot select.
//  One sub-module: prio_pick (NUM_REQ-wide lowest-index priority encoder -> one-hot plus index).
//  Everything else (pending/pendDelay registers, count, FSM) stays in stall_scheduler.
// TESTING
//  1. Reset, then reqEn=001 with delay 5 at edge k -> pcEn=0 for edges k..k+4, pcEn=1 at k+5,
//     done=001 pulse at k+5, grant=001 during the stall.
//  2. reqEn=110 with delays 2 and 3 in the same cycle -> grant 010 for 2 cycles, then 100 for 3 cycles;
//     pcEn low for 5 contiguous cycles; done pulses in order 010 then 100.
//  3. Req 2 (delay 4) granted; req 0 (delay 1) strobes 1 cycle later -> no preemption; req 0 granted at the
//     req-2 completion edge; total stall 5 cycles.
//  4. reqDelay=0 -> 1-cycle stall. Delay 7 -> 7-cycle stall with no counter wrap.
//     Duplicate strobe while pending -> a single service using the first delay.
//  5. Assert reset mid-COUNT (count=3) -> pcEn=1, grant=0, done=0 immediately, with no clock;
//     the pending request is lost.
//  6. Granted requester re-strobes during its own stall -> it is served again back-to-back;
//     two done pulses.

Source files
------------

// File: rtl/stall_scheduler_pkg.sv
// Shared types and helpers for the stall scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkg_stall;

  localparam int DELAY_BITS_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } stateT;

  // Isolates the lowest set bit (two's-complement trick); callers cast to their width.
  function automatic logic [31:0] lowestOneHot(input logic [31:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

endpackage

// File: rtl/stall_scheduler_if.sv
// Request/stall bundle between the stall sources, the PC and the scheduler.
// Latency: n/a (wires only).
// Backpressure: none; requesters strobe and the scheduler latches them.
interface stall_scheduler_if
  import pkg_stall::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DELAY_BITS = DELAY_BITS_DEF
);

  logic [NUM_REQ-1:0]            reqEn;
  logic [NUM_REQ*DELAY_BITS-1:0] reqDelay;
  logic                          pcEn;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;

  modport master (output reqEn, reqDelay, input pcEn, grant, done);
  modport slave  (input reqEn, reqDelay, output pcEn, grant, done);

endinterface

// File: rtl/stall_scheduler_prio_pick.sv
// Lowest-index priority encoder: one-hot winner plus its binary index.
// Latency: combinational.
// Backpressure: none.
module prio_pick
  import pkg_stall::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] oneHot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // One-hot from the shared helper; index scanned high-to-low so the lowest set bit wins.
  always_comb begin
    oneHot = NUM_REQ'(lowestOneHot(32'(req)));
    any    = |req;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stall_scheduler.sv
// Fixed-priority scheduler sharing one PC-stall counter among several stall sources.
// Latency: grant and pcEn=0 at the strobe edge; pcEn returns high exactly D cycles later.
// Backpressure: none; strobes are latched as pending and served one at a time, back-to-back.
module stall_scheduler
  import pkg_stall::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DELAY_BITS = DELAY_BITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  stall_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  stateT                 state;
  logic [DELAY_BITS-1:0] count;
  logic [NUM_REQ-1:0]    pending;
  logic [DELAY_BITS-1:0] pendDelay [NUM_REQ];
  logic [DELAY_BITS-1:0] reqDly    [NUM_REQ];
  logic [NUM_REQ-1:0]    grantR;
  logic [NUM_REQ-1:0]    doneR;
  logic                  pcEnR;

  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    winHot;
  logic [IDX_W-1:0]      winIdx;
  logic                  winAny;
  logic                  slotFree;
  logic                  launch;
  logic [DELAY_BITS-1:0] rawDelay;
  logic [DELAY_BITS-1:0] winDelay;

  assign cand = pending | bus.reqEn;

  prio_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPick (
    .req    (cand),
    .oneHot (winHot),
    .idx    (winIdx),
    .any    (winAny)
  );

  // Winner selection: the counter is free when idle or on the completion edge of the current grant.
  always_comb begin
    slotFree = (state == IDLE) || (count == DELAY_BITS'(1));
    launch   = slotFree && winAny;
    rawDelay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqDly[i] = bus.reqDelay[i*DELAY_BITS +: DELAY_BITS];
      // A latched request keeps its first delay even if it strobes again.
      if (winIdx == IDX_W'(i)) rawDelay = pending[i] ? pendDelay[i] : reqDly[i];
    end
    winDelay = (rawDelay == '0) ? DELAY_BITS'(1) : rawDelay;
  end

  // Pending latch: set on a fresh strobe, cleared when that requester is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < NUM_REQ; i++) pendDelay[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (launch && winHot[i]) begin
          pending[i] <= 1'b0;
        end else if (bus.reqEn[i] && !pending[i]) begin
          pending[i]   <= 1'b1;
          pendDelay[i] <= reqDly[i];
        end
      end
    end
  end

  // Grant FSM: load the counter on a grant, count down to 1, then chain or release the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      grantR <= '0;
      doneR  <= '0;
      pcEnR  <= 1'b1;
    end else begin
      doneR <= '0;
      if (state == IDLE) begin
        if (launch) begin
          grantR <= winHot;
          count  <= winDelay;
          pcEnR  <= 1'b0;
          state  <= COUNT;
        end
      end else if (count > DELAY_BITS'(1)) begin
        count <= count - DELAY_BITS'(1);
      end else begin
        doneR <= grantR;
        if (launch) begin
          grantR <= winHot;
          count  <= winDelay;
        end else begin
          grantR <= '0;
          pcEnR  <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  end

  assign bus.pcEn  = pcEnR;
  assign bus.grant = grantR;
  assign bus.done  = doneR;

endmodule

// File: tb/tb_stall_scheduler.sv
// Self-checking bench for stall_scheduler against a time-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stall_scheduler;

  localparam int NR = 3;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stall_scheduler_if #(.NUM_REQ(NR), .DELAY_BITS(DB)) bus ();

  stall_scheduler #(.NUM_REQ(NR), .DELAY_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: a set of waiting requests and one active service that ends at an absolute edge.
  bit              mPend [NR];
  int              mDly  [NR];
  bit              mActive;
  int              mWho;
  int              mEnd;
  int              tNow;
  logic            mPcEn;
  logic [NR-1:0]   mGrant;
  logic [NR-1:0]   mDone;

  function automatic logic [NR*DB-1:0] dv(input int d2, input int d1, input int d0);
    return {DB'(d2), DB'(d1), DB'(d0)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      mPend[i] = 0;
      mDly[i]  = 0;
    end
    mActive = 0;
    mWho    = 0;
    mEnd    = 0;
    tNow    = 0;
    mPcEn   = 1'b1;
    mGrant  = '0;
    mDone   = '0;
  endtask

  task automatic modelEdge(input logic [NR-1:0] en, input logic [NR*DB-1:0] dl);
    logic [DB-1:0] d;
    bit freeNow;
    tNow++;
    mDone   = '0;
    freeNow = !mActive;
    if (mActive && tNow == mEnd) begin
      mDone[mWho] = 1'b1;
      mActive     = 0;
      freeNow     = 1;
    end
    for (int i = 0; i < NR; i++) begin
      if (en[i] && !mPend[i]) begin
        d        = dl[i*DB +: DB];
        mPend[i] = 1;
        mDly[i]  = (d == 0) ? 1 : int'(d);
      end
    end
    if (freeNow) begin
      for (int i = 0; i < NR; i++) begin
        if (mPend[i] && !mActive) begin
          mActive  = 1;
          mWho     = i;
          mEnd     = tNow + mDly[i];
          mPend[i] = 0;
        end
      end
    end
    mPcEn  = !mActive;
    mGrant = '0;
    if (mActive) mGrant[mWho] = 1'b1;
  endtask

  // One clock: drive, clock, advance model, sample 1ns after the edge; strobe then drops.
  task automatic step(input logic [NR-1:0] en, input logic [NR*DB-1:0] dl);
    bus.reqEn    = en;
    bus.reqDelay = dl;
    @(posedge clk);
    modelEdge(en, dl);
    #1;
    bus.reqEn    = '0;
    bus.reqDelay = NR*DB'($urandom);
  endtask

  task automatic test_reset();
    bus.reqEn    = '0;
    bus.reqDelay = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({bus.pcEn, bus.grant, bus.done} !== {1'b1, 3'b000, 3'b000}) begin
      errs++;
      $display("FAIL reset_hold: pcEn/grant/done=%b/%b/%b want 1/000/000", bus.pcEn, bus.grant, bus.done);
    end
    #3 reset = 1'b0;
    step('0, dv(5, 5, 5));
    vecs++;
    if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
      errs++;
      $display("FAIL reset_idle: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
               bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
    end
  endtask

  task automatic test_single();
    int low = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) step(3'b001, dv(0, 0, 5)); else step(3'b000, dv(7, 7, 7));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL single cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
    end
    vecs++;
    if (low != 5) begin errs++; $display("FAIL single_len: low %0d cycles want 5", low); end
    vecs++;
    if (bus.done !== 3'b001) begin errs++; $display("FAIL single_done: done=%b want 001", bus.done); end
  endtask

  task automatic test_simultaneous();
    int low = 0;
    logic [NR-1:0] seen [$];
    for (int c = 0; c < 6; c++) begin
      if (c == 0) step(3'b110, dv(3, 2, 0)); else step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL simul cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
      if (bus.done !== '0) seen.push_back(bus.done);
    end
    vecs++;
    if (low != 5) begin errs++; $display("FAIL simul_len: low %0d cycles want 5", low); end
    vecs++;
    if (seen.size() != 2 || seen[0] !== 3'b010 || seen[1] !== 3'b100) begin
      errs++;
      $display("FAIL simul_order: %0d done pulses, want 010 then 100", seen.size());
    end
  endtask

  task automatic test_no_preempt();
    int low = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      step(3'b100, dv(4, 0, 0));
      else if (c == 1) step(3'b001, dv(0, 0, 1));
      else             step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL nopreempt cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
    end
    vecs++;
    if (low != 5) begin errs++; $display("FAIL nopreempt_len: low %0d cycles want 5", low); end
  endtask

  task automatic test_delay_edges();
    int low;
    int dn;
    // Delay 0 behaves as 1.
    low = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) step(3'b001, dv(0, 0, 0)); else step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL delay0 cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
    end
    vecs++;
    if (low != 1) begin errs++; $display("FAIL delay0_len: low %0d cycles want 1", low); end
    // Maximum delay, no wrap.
    low = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) step(3'b010, dv(0, 7, 0)); else step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL delay7 cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
    end
    vecs++;
    if (low != 7) begin errs++; $display("FAIL delay7_len: low %0d cycles want 7", low); end
    // Duplicate strobe while pending keeps the first delay and is served once.
    low = 0;
    dn  = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      step(3'b100, dv(2, 0, 0));
      else if (c == 1) step(3'b010, dv(0, 3, 0));
      else if (c == 2) step(3'b010, dv(0, 6, 0));
      else             step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL dup cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
      if (bus.done[1] === 1'b1) dn++;
    end
    vecs++;
    if (low != 5 || dn != 1) begin
      errs++;
      $display("FAIL dup_len: low %0d cycles, %0d done pulses; want 5 and 1", low, dn);
    end
  endtask

  task automatic test_reset_mid();
    step(3'b001, dv(0, 0, 5));
    step(3'b010, dv(0, 4, 0));
    step(3'b000, dv(0, 0, 0));
    #2 reset = 1'b1;
    modelReset();
    #1;
    vecs++;
    if ({bus.pcEn, bus.grant, bus.done} !== {1'b1, 3'b000, 3'b000}) begin
      errs++;
      $display("FAIL reset_mid: pcEn/grant/done=%b/%b/%b want 1/000/000", bus.pcEn, bus.grant, bus.done);
    end
    #2 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL reset_lost cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
    end
  endtask

  task automatic test_rerun();
    int low = 0;
    int dn  = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      step(3'b001, dv(0, 0, 3));
      else if (c == 1) step(3'b001, dv(0, 0, 2));
      else             step(3'b000, dv(0, 0, 0));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL rerun cyc%0d: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
      if (bus.pcEn === 1'b0) low++;
      if (bus.done[0] === 1'b1) dn++;
    end
    vecs++;
    if (low != 5 || dn != 2) begin
      errs++;
      $display("FAIL rerun_len: low %0d cycles, %0d done pulses; want 5 and 2", low, dn);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] en;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(1, 7)) : '0;
      step(en, NR*DB'($urandom));
      vecs++;
      if ({bus.pcEn, bus.grant, bus.done} !== {mPcEn, mGrant, mDone}) begin
        errs++;
        $display("FAIL random cyc%0d en=%b: pcEn/grant/done=%b/%b/%b want %b/%b/%b",
                 c, en, bus.pcEn, bus.grant, bus.done, mPcEn, mGrant, mDone);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_no_preempt();
    test_delay_edges();
    test_reset_mid();
    test_rerun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
